sdrx_frame: RTL and testbench
=============================

SDRX_FRAME -- requirements
Module: sdrx_frame

Interface
REQ-001 SHALL have parameter LGMAXBLK, default 9, giving log2 of the maximum block length in bytes (512).
REQ-002 SHALL have port i_clk, input, 1 bit, the single clock for all logic.
REQ-003 SHALL have port i_reset, input, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1 bit, a one-cycle pulse that arms reception of one block.
REQ-005 SHALL have port i_abort, input, 1 bit, which cancels reception.
REQ-006 SHALL have port i_lgblk, input, 4 bits, log2 of the block length in bytes; it is sampled on i_start.
REQ-007 SHALL have port i_stb, input, 1 bit, which marks one valid sample of the card DAT lines per SD clock.
REQ-008 SHALL have port i_data, input, 4 bits, the sampled DAT[3:0] lines, with DAT3 as MSB.
REQ-009 SHALL have port o_byte_stb, output, 1 bit, a one-cycle strobe marking o_byte valid.
REQ-010 SHALL have port o_byte, output, 8 bits, the received data byte.
REQ-011 SHALL have port o_done, output, 1 bit, a one-cycle pulse at end of frame.
REQ-012 SHALL have port o_crc_err, output, 1 bit, which flags that any line's CRC16 failed.
REQ-013 SHALL have port o_frame_err, output, 1 bit, which flags a bad start or end bit, or an abort.
REQ-014 SHALL have port o_busy, output, 1 bit, high from arm until o_done.

Function
REQ-015 SHALL implement states IDLE, WAIT_START, DATA, CRC, ENDBIT.
REQ-016 SHALL, in IDLE with i_start high, latch the block length, clear o_crc_err and o_frame_err, zero all counters and CRCs, and enter WAIT_START next cycle.
REQ-017 SHALL clamp the latched length so that i_lgblk < 2 gives 2 and i_lgblk > LGMAXBLK gives LGMAXBLK.
REQ-018 SHALL ignore i_start outside IDLE.
REQ-019 SHALL advance state, counters and CRCs only on cycles with i_stb high, except for i_abort.
REQ-020 SHALL, in WAIT_START: treat i_data==4'hF as idle and stay; treat i_data==4'h0 as the start bit and go to DATA; treat any other value as a start error, set o_frame_err, and go to ENDBIT-complete (REQ-026 timing).
REQ-021 SHALL, in DATA, take the even-numbered nibble (0,2,...) as byte[7:4] and the odd-numbered nibble as byte[3:0].
REQ-022 SHALL assert o_byte_stb with o_byte on the cycle after the i_stb carrying the odd nibble.
REQ-023 SHALL exit DATA after exactly 2<<len nibbles, i.e. 2^len bytes, with a counter width of LGMAXBLK+2 bits and no wrap.
REQ-024 SHALL keep four independent CRC16 registers, one per line, using polynomial 0x1021 with init 0, each shifting in its line's bit on every DATA strobe.
REQ-025 SHALL, in CRC for 16 strobes, continue shifting the received CRC bits (MSB first) through the same registers; a line passes if its register is 0 after the 16th bit.
REQ-026 SHALL, in ENDBIT, require i_data==4'hF on the next strobe, setting o_frame_err otherwise; on the cycle after that strobe, pulse o_done, set o_crc_err if any line failed, and return to IDLE.
REQ-027 SHALL, when i_abort is high in any non-IDLE state, go to IDLE next cycle, pulse o_done, set o_frame_err, and emit no further o_byte_stb.
REQ-028 SHALL give i_abort priority over i_stb in the same cycle.
REQ-029 SHALL hold o_crc_err and o_frame_err stable from o_done until the next accepted i_start.
REQ-030 SHALL hold o_byte stable between strobes.
REQ-031 SHALL assert o_busy from the cycle after an accepted i_start until the o_done cycle inclusive.
REQ-032 SHALL, on back-to-back i_stb at every clock, sustain one byte per two clocks with no lost samples.

Reset
REQ-033 SHALL, on i_reset high at any clock edge including mid-frame, force IDLE, and drive o_byte_stb=0, o_done=0, o_busy=0, o_crc_err=0, o_frame_err=0 and o_byte=8'h00 next cycle.
REQ-034 SHALL give reset priority over i_start and i_abort.
REQ-035 SHALL emit no o_done pulse as a result of reset.

Verification
REQ-036 Bench SHALL cover: len=2 block 8'hDE,AD,BE,EF with correct per-line CRCs and end bit F -> 4 byte strobes in order, one o_done, crc_err=0, frame_err=0.
REQ-037 Bench SHALL cover: a 512-byte incrementing pattern with one flipped CRC bit on DAT2 -> 512 strobes, o_done, crc_err=1, frame_err=0.
REQ-038 Bench SHALL cover: start nibble 4'h8 in WAIT_START -> no byte strobes, o_done, frame_err=1.
REQ-039 Bench SHALL cover: end nibble 4'h7 with good CRC -> o_done, frame_err=1, crc_err=0.
REQ-040 Bench SHALL cover: i_abort after 3 bytes coinciding with i_stb -> exactly 3 strobes, o_done next cycle, frame_err=1, busy=0 after.
REQ-041 Bench SHALL cover: i_reset mid-DATA, then i_lgblk=1 block -> all outputs 0, IDLE; the block is received as 4 bytes (clamped).

Source files
------------

// File: rtl/sdrx_frame.sv
// SD card 4-bit data-block receiver: finds the start bit, assembles bytes from
// nibble pairs, checks one CRC16 per DAT line and verifies the end bit.
module sdrx_frame #(
   parameter int LGMAXBLK = 9
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic       i_abort,
   input  logic [3:0] i_lgblk,
   input  logic       i_stb,
   input  logic [3:0] i_data,
   output logic       o_byte_stb,
   output logic [7:0] o_byte,
   output logic       o_done,
   output logic       o_crc_err,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int CW = LGMAXBLK + 2;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      ENDBIT
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [3:0]    len;
   logic [3:0]    lg_clamp;
   logic [CW-1:0] cnt;
   logic [CW-1:0] last_nib;
   logic [3:0]    hi_nib;
   logic [15:0]   crc [4];
   logic          crc_bad;

   logic arm;
   logic abort_now;
   logic finish;
   logic frame_bad;
   logic byte_fire;
   logic hi_load;
   logic crc_shift;
   logic cnt_inc;
   logic cnt_clr;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
   endfunction

   always_comb begin
      if (i_lgblk < 4'd2)
         lg_clamp = 4'd2;
      else if (int'(i_lgblk) > LGMAXBLK)
         lg_clamp = 4'(LGMAXBLK);
      else
         lg_clamp = i_lgblk;
   end

   // A block of 2^len bytes is 2<<len nibbles; the counter runs 0 .. last_nib.
   assign last_nib = (CW'(2) << len) - CW'(1);
   assign crc_bad  = (crc[0] != 16'h0) || (crc[1] != 16'h0) ||
                     (crc[2] != 16'h0) || (crc[3] != 16'h0);
   assign o_busy   = (state != IDLE) || o_done;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      arm        = 1'b0;
      abort_now  = 1'b0;
      finish     = 1'b0;
      frame_bad  = 1'b0;
      byte_fire  = 1'b0;
      hi_load    = 1'b0;
      crc_shift  = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      if (state == IDLE) begin
         if (i_start) begin
            arm        = 1'b1;
            state_next = WAIT_START;
         end
      end else if (i_abort) begin
         abort_now  = 1'b1;
         state_next = IDLE;
      end else if (i_stb) begin
         case (state)
            WAIT_START: begin
               if (i_data == 4'h0) begin
                  state_next = DATA;
               end else if (i_data != 4'hF) begin
                  frame_bad  = 1'b1;
                  finish     = 1'b1;
                  state_next = IDLE;
               end
            end
            DATA: begin
               crc_shift = 1'b1;
               cnt_inc   = 1'b1;
               byte_fire = cnt[0];
               hi_load   = ~cnt[0];
               if (cnt == last_nib) begin
                  cnt_clr    = 1'b1;
                  state_next = CRC;
               end
            end
            CRC: begin
               crc_shift = 1'b1;
               cnt_inc   = 1'b1;
               if (cnt == CW'(15)) begin
                  cnt_clr    = 1'b1;
                  state_next = ENDBIT;
               end
            end
            ENDBIT: begin
               finish     = 1'b1;
               frame_bad  = (i_data != 4'hF);
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Received CRC bits pass through the same registers, so a good line ends at zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         len         <= 4'd0;
         cnt         <= '0;
         hi_nib      <= 4'd0;
         o_byte_stb  <= 1'b0;
         o_byte      <= 8'h00;
         o_done      <= 1'b0;
         o_crc_err   <= 1'b0;
         o_frame_err <= 1'b0;
         for (int k = 0; k < 4; k++)
            crc[k] <= 16'h0;
      end else begin
         o_byte_stb <= byte_fire;
         o_done     <= finish | abort_now;
         if (arm) begin
            len         <= lg_clamp;
            o_crc_err   <= 1'b0;
            o_frame_err <= 1'b0;
         end
         if (arm || cnt_clr)
            cnt <= '0;
         else if (cnt_inc)
            cnt <= cnt + CW'(1);
         for (int k = 0; k < 4; k++) begin
            if (arm)
               crc[k] <= 16'h0;
            else if (crc_shift)
               crc[k] <= crc_step(crc[k], i_data[k]);
         end
         if (hi_load)
            hi_nib <= i_data;
         if (byte_fire)
            o_byte <= {hi_nib, i_data};
         if (frame_bad || abort_now)
            o_frame_err <= 1'b1;
         if (finish && crc_bad)
            o_crc_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdrx_frame.sv
// Directed bench for sdrx_frame: a table of frames plus hand-written abort and
// mid-frame reset sequences, with a CRC16 reference for the per-line checksums.
module tb_sdrx_frame;

   logic       i_clk;
   logic       i_reset;
   logic       i_start;
   logic       i_abort;
   logic [3:0] i_lgblk;
   logic       i_stb;
   logic [3:0] i_data;
   logic       o_byte_stb;
   logic [7:0] o_byte;
   logic       o_done;
   logic       o_crc_err;
   logic       o_frame_err;
   logic       o_busy;

   typedef struct {
      logic [3:0] lg;
      int         nbytes;
      int         exp_n;
      bit         pat;
      logic [3:0] start_nib;
      logic [3:0] end_nib;
      bit         flip;
      bit         gap;
      bit         exp_crc;
      bit         exp_frame;
   } vec_t;

   vec_t       vecs [7];
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] last_byte;
   int         done_cnt;
   int         stable_viol;
   int         n_cmp;
   int         n_fail;

   sdrx_frame #(.LGMAXBLK(9)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_lgblk     (i_lgblk),
      .i_stb       (i_stb),
      .i_data      (i_data),
      .o_byte_stb  (o_byte_stb),
      .o_byte      (o_byte),
      .o_done      (o_done),
      .o_crc_err   (o_crc_err),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Collects byte strobes and done pulses, and watches o_byte between strobes.
   always @(negedge i_clk) begin
      if (i_reset) begin
         last_byte = o_byte;
      end else begin
         if (o_byte_stb)
            got_q.push_back(o_byte);
         else if (o_byte !== last_byte)
            stable_viol++;
         last_byte = o_byte;
         if (o_done)
            done_cnt++;
      end
   end

   function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      ref_crc = c << 1;
      if (fb)
         ref_crc = ref_crc ^ 16'h1021;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic stb, input logic [3:0] d);
      i_stb  = stb;
      i_data = d;
      @(posedge i_clk);
      #1;
      i_stb = 1'b0;
   endtask

   task automatic clear_monitor();
      got_q.delete();
      exp_q.delete();
      done_cnt    = 0;
      stable_viol = 0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      logic [7:0]  fixed [4];
      logic [7:0]  b;
      logic [3:0]  nib;
      logic [3:0]  nibs [$];
      logic [15:0] crc [4];
      fixed[0] = 8'hDE;
      fixed[1] = 8'hAD;
      fixed[2] = 8'hBE;
      fixed[3] = 8'hEF;
      for (int k = 0; k < 4; k++)
         crc[k] = 16'h0;
      clear_monitor();
      for (int i = 0; i < v.nbytes; i++) begin
         b = v.pat ? 8'(i) : fixed[i % 4];
         if (v.start_nib == 4'h0)
            exp_q.push_back(b);
         for (int h = 0; h < 2; h++) begin
            nib = (h == 0) ? b[7:4] : b[3:0];
            for (int k = 0; k < 4; k++)
               crc[k] = ref_crc(crc[k], nib[k]);
            nibs.push_back(nib);
         end
      end
      for (int j = 0; j < 16; j++) begin
         for (int k = 0; k < 4; k++)
            nib[k] = crc[k][15-j];
         if (v.flip && j == 5)
            nib[2] = ~nib[2];
         nibs.push_back(nib);
      end
      i_lgblk = v.lg;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_lgblk = 4'h0;
      drive(1'b1, 4'hF);
      drive(1'b0, 4'h5);
      drive(1'b1, 4'hF);
      drive(1'b1, v.start_nib);
      if (v.start_nib == 4'h0) begin
         foreach (nibs[i]) begin
            drive(1'b1, nibs[i]);
            if (v.gap)
               drive(1'b0, 4'h5);
         end
         drive(1'b1, v.end_nib);
      end
      drive(1'b0, 4'hF);
   endtask

   task automatic check_output(input string tag, input vec_t v);
      int bad;
      int n;
      for (int c = 0; c < 40 && done_cnt == 0; c++)
         @(posedge i_clk);
      repeat (4) @(posedge i_clk);
      #1;
      bad = 0;
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         if (got_q[i] !== exp_q[i])
            bad++;
      check({tag, " byte_count"}, got_q.size(), v.exp_n);
      check({tag, " bytes_wrong"}, bad, 0);
      check({tag, " done_pulses"}, done_cnt, 1);
      check({tag, " crc_err"}, {31'b0, o_crc_err}, {31'b0, v.exp_crc});
      check({tag, " frame_err"}, {31'b0, o_frame_err}, {31'b0, v.exp_frame});
      check({tag, " busy_after"}, {31'b0, o_busy}, 0);
      check({tag, " byte_hold"}, stable_viol, 0);
   endtask

   initial begin
      vec_t rv;
      n_cmp     = 0;
      n_fail    = 0;
      done_cnt  = 0;
      last_byte = 8'h00;
      i_reset   = 1'b1;
      i_start   = 1'b0;
      i_abort   = 1'b0;
      i_lgblk   = 4'h0;
      i_stb     = 1'b0;
      i_data    = 4'hF;

      vecs[0] = '{4'd2,  4,   4,   1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd9,  512, 512, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{4'd2,  4,   0,   1'b0, 4'h8, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{4'd2,  4,   4,   1'b0, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{4'd0,  4,   4,   1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{4'd15, 512, 512, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{4'd3,  8,   8,   1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0};

      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      check("reset byte_stb", {31'b0, o_byte_stb}, 0);
      check("reset byte", {24'b0, o_byte}, 0);
      check("reset done", {31'b0, o_done}, 0);
      check("reset busy", {31'b0, o_busy}, 0);
      check("reset crc_err", {31'b0, o_crc_err}, 0);
      check("reset frame_err", {31'b0, o_frame_err}, 0);

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i]);
         check_output($sformatf("vec%0d", i), vecs[i]);
      end

      // Abort on the strobe that would carry the 7th nibble, with a stray i_start mid-data.
      clear_monitor();
      i_lgblk = 4'd2;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      drive(1'b1, 4'hF);
      drive(1'b1, 4'h0);
      drive(1'b1, 4'hD);
      drive(1'b1, 4'hE);
      drive(1'b1, 4'hA);
      i_lgblk = 4'd9;
      i_start = 1'b1;
      drive(1'b1, 4'hD);
      i_start = 1'b0;
      drive(1'b1, 4'hB);
      drive(1'b1, 4'hE);
      i_abort = 1'b1;
      drive(1'b1, 4'hE);
      i_abort = 1'b0;
      check("abort done", {31'b0, o_done}, 1);
      check("abort frame_err", {31'b0, o_frame_err}, 1);
      check("abort busy_done_cycle", {31'b0, o_busy}, 1);
      drive(1'b0, 4'hF);
      check("abort busy_after", {31'b0, o_busy}, 0);
      drive(1'b1, 4'h1);
      drive(1'b1, 4'h2);
      drive(1'b1, 4'h3);
      repeat (2) @(posedge i_clk);
      #1;
      check("abort byte_count", got_q.size(), 3);
      check("abort bytes", (got_q.size() == 3) ? {8'h0, got_q[0], got_q[1], got_q[2]} : 32'hFFFF_FFFF,
            32'h00DE_ADBE);
      check("abort done_pulses", done_cnt, 1);
      check("abort crc_err", {31'b0, o_crc_err}, 0);

      // Reset in DATA with i_start and i_abort also high; reset must win quietly.
      clear_monitor();
      i_lgblk = 4'd2;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      drive(1'b1, 4'hF);
      drive(1'b1, 4'h0);
      drive(1'b1, 4'h3);
      i_reset = 1'b1;
      i_start = 1'b1;
      i_abort = 1'b1;
      i_stb   = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst byte_stb", {31'b0, o_byte_stb}, 0);
      check("rst done", {31'b0, o_done}, 0);
      check("rst busy", {31'b0, o_busy}, 0);
      check("rst frame_err", {31'b0, o_frame_err}, 0);
      check("rst byte", {24'b0, o_byte}, 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_stb   = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst idle_busy", {31'b0, o_busy}, 0);
      check("rst no_done", done_cnt, 0);
      check("rst no_bytes", got_q.size(), 0);

      rv = '{4'd1, 4, 4, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
      apply_stimulus(rv);
      check_output("clamp_lg1", rv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
